// File: rtl/zigzag_pkg.sv
// Shared constants, types and helpers for the zigzag reorder buffer.
package zigzag_pkg;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned LANES  = 8;
  localparam int unsigned DEPTH  = LANES * LANES;

  typedef logic [COEF_W-1:0]       coef_t;
  typedef logic [5:0]              addr_t;
  typedef logic [LANES*COEF_W-1:0] word_t;

  // Scan index -> raster address (row*8 + col) for the JPEG zigzag order.
  localparam addr_t ZZ_ADDR [DEPTH] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Clamp a COEF_W+1 bit two's complement difference into COEF_W bits.
  function automatic coef_t sat_coef(input logic [COEF_W:0] diff);
    coef_t res;
    if (diff[COEF_W] != diff[COEF_W-1]) begin
      res = diff[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}} : {1'b0, {(COEF_W-1){1'b1}}};
    end else begin
      res = diff[COEF_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/zigzag_buffer_zz_bank_ram.sv
// One 64 x COEF_W block bank: 8-lane column write port, combinational read port.
module zz_bank_ram
  import zigzag_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  logic  [2:0] col,
  input  word_t wdata,
  input  addr_t raddr,
  output coef_t rdata
);

  coef_t mem [DEPTH];

  // Column write: lane r (MSB lane is row 0) lands at raster address r*8 + col.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int r = 0; r < int'(LANES); r++) begin
        mem[{3'(r), col}] <= wdata[(int'(LANES) - 1 - r) * int'(COEF_W) +: COEF_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 block buffer: captures columns, emits coefficients in zigzag order.
// Optional feature: define ZIGZAG_DC_DIFF_EN to emit the DC coefficient as a
// saturated difference against the previous block's DC.
module zigzag_buffer
  import zigzag_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  word_t       in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output coef_t       out_data,
  output logic [5:0]  out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] wr_col_q, wr_col_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic [1:0] full_q, full_d;

  logic  wr_fire, rd_fire;
  addr_t raddr;
  coef_t bank_rdata [2];
  coef_t raw_coef;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign raddr     = ZZ_ADDR[rd_idx_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank_ram u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_bank_q == 1'(b))),
      .col   (wr_col_q),
      .wdata (in_data),
      .raddr (raddr),
      .rdata (bank_rdata[b])
    );
  end

  assign raw_coef  = bank_rdata[rd_bank_q];
  assign out_index = rd_idx_q;
  assign out_last  = out_valid && (rd_idx_q == 6'd63);

`ifdef ZIGZAG_DC_DIFF_EN
  coef_t             prev_dc_q;
  logic [COEF_W:0]   dc_diff;

  // ZZ_ADDR[0] is raster 0, so at scan index 0 raw_coef already is the DC term.
  assign dc_diff  = {raw_coef[COEF_W-1], raw_coef} - {prev_dc_q[COEF_W-1], prev_dc_q};
  assign out_data = (rd_idx_q == 6'd0) ? sat_coef(dc_diff) : raw_coef;

  // Remember the DC of each block once its index 0 is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_dc_q <= '0;
    end else if (rd_fire && (rd_idx_q == 6'd0)) begin
      prev_dc_q <= raw_coef;
    end
  end
`else
  assign out_data = raw_coef;
`endif

  // Next-state for write/read pointers and bank full flags.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_col_d  = wr_col_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    if (wr_fire) begin
      wr_col_d = wr_col_q + 3'd1;
      if (wr_col_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    // Write targets a non-full bank, read a full one: never the same flag bit.
    if (rd_fire) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_col_q  <= 3'd0;
      rd_idx_q  <= 6'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_col_q  <= wr_col_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
    end
  end

endmodule
